// File: rtl/message_receive_cu.sv
// Serial-to-parallel message receiver with a ready/ack handoff to the consumer.
// Flags truncated frames (frame_err pulse) and traffic during an unacked message (sticky overrun).
module message_receive_cu #(
  parameter int MSG_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 serial_in,
  input  logic                 valid_in,
  input  logic                 ack,
  input  logic                 clr_ovr,
  output logic [MSG_WIDTH-1:0] message_out,
  output logic                 msg_ready,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(MSG_WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RECEIVING, HOLD, SKIP} state_e;

  state_e               state_q, state_d;
  logic [MSG_WIDTH-1:0] shreg_q, shreg_d;
  logic [MSG_WIDTH-1:0] msg_q, msg_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [MSG_WIDTH-1:0] shin;
  logic                 ovr_set;

  // shreg_q is held at zero outside RECEIVING, so the IDLE capture can reuse shin
  always_comb begin
    if (MSB_FIRST) shin = {shreg_q[MSG_WIDTH-2:0], serial_in};
    else           shin = {serial_in, shreg_q[MSG_WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    msg_d   = msg_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    ferr_d  = 1'b0;
    ovr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (valid_in) begin
          shreg_d = shin;
          cnt_d   = CW'(1);
          busy_d  = 1'b1;
          state_d = RECEIVING;
        end
      end
      RECEIVING: begin
        if (valid_in) begin
          if (cnt_q == CW'(MSG_WIDTH - 1)) begin
            msg_d   = shin;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            cnt_d   = '0;
            shreg_d = '0;
            state_d = HOLD;
          end else begin
            shreg_d = shin;
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          ferr_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          shreg_d = '0;
          state_d = IDLE;
        end
      end
      HOLD: begin
        ovr_set = valid_in;
        if (ack) begin
          ready_d = 1'b0;
          state_d = valid_in ? SKIP : IDLE;
        end
      end
      SKIP: begin
        if (!valid_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // set has priority over clear
    if (ovr_set)      ovr_d = 1'b1;
    else if (clr_ovr) ovr_d = 1'b0;
    else              ovr_d = ovr_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      msg_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      msg_q   <= msg_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign message_out = msg_q;
  assign msg_ready   = ready_q;
  assign busy        = busy_q;
  assign frame_err   = ferr_q;
  assign overrun     = ovr_q;

endmodule

// File: doc/message_receive_cu.md
Name: message_receive_cu

Overview:
- Receive-side counterpart of the message transmit control path.
- Samples a serial bit stream qualified by a valid strobe, which the transmitter holds high for exactly MSG_WIDTH consecutive cycles per message.
- Assembles each message into a parallel word and presents it to a downstream consumer with a ready/ack handshake.
- Sits between the serial link input and the consumer logic (display/decode). Reports truncated frames and overruns.

Parameters:
- MSG_WIDTH, 8, bits per message; legal range 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in message_out[MSG_WIDTH-1]; 0 = first bit lands in message_out[0].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- serial_in  in  1  serial data bit; sampled only when valid_in=1.
- valid_in  in  1  frame-qualifying strobe from the transmitter.
- ack  in  1  consumer has taken message_out; one-cycle pulse or level.
- clr_ovr  in  1  synchronous clear of the sticky overrun flag.
- message_out  out  MSG_WIDTH  assembled message; stable while msg_ready=1.
- msg_ready  out  1  a complete message is held on message_out.
- busy  out  1  high while a frame is being received (state RECEIVING).
- frame_err  out  1  one-cycle pulse: frame ended early.
- overrun  out  1  sticky: traffic arrived while a message was unacknowledged.

Behaviour:
- Reset (reset=0, async): state=IDLE; shift register, bit counter and message_out = 0; msg_ready, busy, frame_err, overrun = 0. Reset mid-frame discards the partial frame.
- All outputs are registered. Every state transition occurs on the rising edge of clk.
- States: IDLE, RECEIVING, HOLD, SKIP.
- IDLE:
  - On valid_in=1, capture serial_in as bit 1 of the frame and set cnt=1.
  - Transition to RECEIVING; busy=1 from the next cycle.
- RECEIVING, valid_in=1:
  - Shift in serial_in; cnt increments.
  - When the captured bit is bit number MSG_WIDTH (cnt==MSG_WIDTH-1 before the capture):
    - load message_out with the full word;
    - set msg_ready=1 in the same edge;
    - set busy=0 and cnt=0;
    - go to HOLD.
  - Latency: msg_ready rises 1 cycle after the last valid bit is sampled.
- RECEIVING, valid_in=0 before the frame completes:
  - frame_err pulses high for exactly 1 cycle.
  - Partial data is discarded; message_out keeps its previous value.
  - Go to IDLE.
- HOLD:
  - msg_ready=1; message_out frozen.
  - Any cycle with valid_in=1 sets overrun=1.
  - On ack=1:
    - msg_ready=0 next cycle;
    - if valid_in=0 in the same cycle, go to IDLE;
    - if valid_in=1, set overrun and go to SKIP.
  - ack is ignored in every state other than HOLD.
- SKIP: ignore serial_in until valid_in=0, then go to IDLE. This prevents resynchronising on the tail of a frame.
- HOLD with valid_in=1 and no ack: bits are dropped. Once ack arrives, a still-high valid_in routes through SKIP; an already-low valid_in routes to IDLE.
- overrun:
  - Set by the HOLD conditions above.
  - Cleared only by clr_ovr=1 or by reset.
  - If set and clr_ovr occur in the same cycle, set wins.
- Bit ordering:
  - MSB_FIRST=1: shift left, inserting at bit 0. First bit ends in bit MSG_WIDTH-1.
  - MSB_FIRST=0: shift right, inserting at bit MSG_WIDTH-1. First bit ends in bit 0.
- Counter width is clog2(MSG_WIDTH)+1. The counter never wraps: it resets to 0 on completion, on abort and on reset.
- Back-to-back frames: the transmitter guarantees at least 1 low cycle of valid_in between frames. When ack arrives at or before that gap, the next frame is received without loss.

Test Plan:
- MSG_WIDTH=8, MSB_FIRST=1; send bits 1,0,1,1,0,0,1,0 with valid_in high for 8 cycles -> message_out=0xB2 and msg_ready=1 one cycle after the 8th bit; busy high for exactly 7 cycles.
- Same bits with MSB_FIRST=0 -> message_out=0x4D.
- valid_in drops after 5 bits -> frame_err pulses for 1 cycle; msg_ready stays 0; the next full frame 0xFF is received correctly as 0xFF.
- Receive 0xB2 without ack, then send a second frame 0x3C -> overrun=1; message_out stays 0xB2. Ack mid-frame -> msg_ready=0, FSM passes through SKIP, and 0x3C is not delivered. clr_ovr -> overrun=0.
- Receive 0xB2, ack during the 1-cycle gap, then frame 0x5A -> msg_ready for 0x5A with overrun=0.
- Assert reset low asynchronously after 4 bits -> all outputs 0 immediately; after release, a full frame 0xA5 is received correctly.
